// File: rtl/token_multiplier.sv
// Serial token multiplier: each '1' on a owes mult tokens, drained one per enabled cycle on b.
// Optional build macro TOKEN_MULTIPLIER_REG_OUT_EN registers b (one cycle latency).
module token_multiplier #(
    parameter int MULT_W      = 2,
    parameter int MAX_PENDING = 200,
    parameter int CNT_W       = $clog2(MAX_PENDING + 2**MULT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a,
    input  logic [MULT_W-1:0] mult,
    input  logic              out_en,
    output logic              b,
    output logic [CNT_W-1:0]  pending,
    output logic              busy,
    output logic              overflow
);

    localparam logic [CNT_W:0] MAX_P = (CNT_W+1)'(MAX_PENDING);

    logic [CNT_W:0] add;
    logic [CNT_W:0] total;
    logic [CNT_W:0] nxt;
    logic           b_c;

    // One extra bit on total/nxt so the saturation compare never sees a wrapped value
    always_comb begin
        add   = a ? (CNT_W+1)'(mult) : '0;
        total = {1'b0, pending} + add;
        b_c   = out_en & (total != '0);
        nxt   = total - (CNT_W+1)'(b_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (nxt > MAX_P) begin
            pending  <= MAX_P[CNT_W-1:0];
            overflow <= 1'b1;
        end else begin
            pending  <= nxt[CNT_W-1:0];
        end
    end

    always_comb busy = (pending != '0);

`ifdef TOKEN_MULTIPLIER_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) b <= 1'b0;
        else     b <= b_c;
    end
`else
    always_comb b = b_c & ~rst;
`endif

endmodule

// File: doc/token_multiplier.md
# token_multiplier

Parametrised serial token multiplier for the sequential-basics block set. Every `1` token on the serial input `a` is replicated a run-time-selectable number of times on the serial output `b`. Owed tokens accumulate in a bounded credit counter, and `b` drains that counter one token per cycle while downstream allows it. Exceeding the configured capacity raises a sticky `overflow` flag that only `rst` clears.

## Interface
- `MULT_W`, default 2: width of the run-time multiplier input `mult`.
- `MAX_PENDING`, default 200: maximum owed tokens held in the credit counter.
- `CNT_W`, default `$clog2(MAX_PENDING + 2**MULT_W + 1)`: credit-counter width. Derived; do not override.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `a`, input, 1: serial token input; `1` means one token this cycle.
- `mult`, input, `MULT_W`: replication factor applied to the token arriving this cycle; 0 means the token is dropped.
- `out_en`, input, 1: downstream enable; while 0, `b` is held 0 and nothing drains.
- `b`, output, 1: serial token output.
- `pending`, output, `CNT_W`: current registered credit count.
- `busy`, output, 1: high when `pending != 0`.
- `overflow`, output, 1: sticky overflow flag.

## Operation
- Per cycle, combinationally:
  - `total = pending + (a ? mult : 0)`, computed at `CNT_W+1` bits so it cannot wrap.
  - `b = out_en & (total != 0)`.
  - `nxt = total - b`.
- Register update:
  - If `nxt <= MAX_PENDING`: `pending <= nxt`.
  - Otherwise: `pending <= MAX_PENDING` (saturate), `overflow <= 1`. Excess tokens are discarded.
- `overflow` is sticky. Once set, it stays 1 until `rst`. The counter keeps operating after overflow: it drains, accepts tokens and saturates again as needed.
- With `mult = 2` and `MAX_PENDING = 200`, the block holds exactly 200 consecutive `1`s; the 201st consecutive `1` overflows.
- `mult = 1` makes `b` equal `a` whenever `pending` is 0 and `out_en` is 1.
- A token arriving in the same cycle that `b` drains is counted in the same `total`. No arbitration is needed.
- `out_en = 0` with `a = 1` still accumulates `mult` credits. The overflow check applies normally.
- `busy` is `pending != 0` taken from the register. It is not `total`.
- Reset values: `pending = 0`, `overflow = 0`, `busy = 0`. `b = 0` in every cycle where `rst = 1`, regardless of `a`.
- Reset mid-burst discards all owed tokens. The first cycle after reset behaves as if the block were idle.

## Timing
- Default build: `b` is combinational from `a`, `mult`, `out_en` and the `pending` register. Zero latency: the first replica appears in the same cycle as the input token.
- A token with `mult = M` on an otherwise idle, enabled block gives `b = 1` for exactly M consecutive cycles, starting that cycle.
- `pending`, `busy` and `overflow` are registered. `overflow` rises on the edge that ends the offending cycle.
- `rst` takes effect on the clock edge only. No asynchronous path.

## Configuration
- `TOKEN_MULTIPLIER_REG_OUT_EN` defined:
  - `b` is registered: `b` equals the combinational value from the previous cycle, and `b` resets to 0.
  - Latency becomes 1 cycle. The counter arithmetic and overflow behaviour are unchanged.
- Not defined: `b` is combinational as described under Timing.

## Test plan
- **Reference pattern:** `mult = 2`, `out_en = 1`, `a = 10010011000110100001100100` -> `b = 11011011110111111001111110`; `overflow` stays 0.
- **Capacity boundary:** `mult = 2`.
  - 200 consecutive `1`s -> `pending = 200`, `overflow = 0`.
  - A 201st `1` -> `overflow = 1` on the next edge and `pending = 200`.
  - Then `a = 0` -> `b` drains 200 cycles of `1`, then 0; `overflow` stays 1.
- **Variable factor:** single tokens with `mult = 3`, then `0`, then `1` on an idle block -> `b` runs of 3, 0 and 1 cycles respectively.
- **Stall:** `mult = 2`, `a = 1` for 4 cycles with `out_en = 0` -> `b = 0` and `pending = 8`. Then `out_en = 1` with `a = 0` -> 8 cycles of `b = 1`.
- **Reset mid-operation:**
  - Assert `rst` for 1 cycle while `pending = 50` and `overflow = 1` -> next cycle `pending = 0`, `overflow = 0`, `b = 0`.
  - `b = 0` also in the reset cycle itself, even with `a = 1`.
- **REG_OUT build:** repeat the reference pattern with `TOKEN_MULTIPLIER_REG_OUT_EN` defined -> same `b` sequence delayed by one cycle, with `b = 0` in the first cycle.
